// File: rtl/rasterizer_pkg.sv
// Shared types and sizing helpers for the triangle rasterizer scan path.
// Holds the scan FSM state encoding and the coordinate width functions.
package rasterizer_pkg;

   localparam int DEF_VERT_RESOLUTION  = 60;
   localparam int DEF_HORIZ_RESOLUTION = 80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_LOADED,
      ST_SETTLE,
      ST_EMIT,
      ST_DONE
   } scan_state_e;

   // A resolution of 1 still needs a one-bit coordinate.
   function automatic int calc_xw(input int horiz_resolution);
      return (horiz_resolution > 1) ? $clog2(horiz_resolution) : 1;
   endfunction

   function automatic int calc_yw(input int vert_resolution);
      return (vert_resolution > 1) ? $clog2(vert_resolution) : 1;
   endfunction

endpackage

// File: rtl/rasterizer_bounding_box.sv
// Combinational bounding box of three vertices, each bound clamped to the
// last on-screen column/row so the scan never leaves the screen.
module rasterizer_bounding_box
   import rasterizer_pkg::*;
#(
   parameter int VERT_RESOLUTION  = DEF_VERT_RESOLUTION,
   parameter int HORIZ_RESOLUTION = DEF_HORIZ_RESOLUTION,
   localparam int XW = calc_xw(HORIZ_RESOLUTION),
   localparam int YW = calc_yw(VERT_RESOLUTION)
) (
   input  logic [XW-1:0] point_0_x_i,
   input  logic [YW-1:0] point_0_y_i,
   input  logic [XW-1:0] point_1_x_i,
   input  logic [YW-1:0] point_1_y_i,
   input  logic [XW-1:0] point_2_x_i,
   input  logic [YW-1:0] point_2_y_i,
   output logic [XW-1:0] xmin_o,
   output logic [XW-1:0] xmax_o,
   output logic [YW-1:0] ymin_o,
   output logic [YW-1:0] ymax_o
);

   localparam logic [XW-1:0] X_LIMIT = XW'(HORIZ_RESOLUTION - 1);
   localparam logic [YW-1:0] Y_LIMIT = YW'(VERT_RESOLUTION - 1);

   logic [XW-1:0] x_lo, x_hi;
   logic [YW-1:0] y_lo, y_hi;

   always_comb begin
      x_lo = point_0_x_i;
      x_hi = point_0_x_i;
      if (point_1_x_i < x_lo) x_lo = point_1_x_i;
      if (point_2_x_i < x_lo) x_lo = point_2_x_i;
      if (point_1_x_i > x_hi) x_hi = point_1_x_i;
      if (point_2_x_i > x_hi) x_hi = point_2_x_i;

      y_lo = point_0_y_i;
      y_hi = point_0_y_i;
      if (point_1_y_i < y_lo) y_lo = point_1_y_i;
      if (point_2_y_i < y_lo) y_lo = point_2_y_i;
      if (point_1_y_i > y_hi) y_hi = point_1_y_i;
      if (point_2_y_i > y_hi) y_hi = point_2_y_i;
   end

   assign xmin_o = (x_lo > X_LIMIT) ? X_LIMIT : x_lo;
   assign xmax_o = (x_hi > X_LIMIT) ? X_LIMIT : x_hi;
   assign ymin_o = (y_lo > Y_LIMIT) ? Y_LIMIT : y_lo;
   assign ymax_o = (y_hi > Y_LIMIT) ? Y_LIMIT : y_hi;

endmodule

// File: rtl/rasterizer_scan_controller.sv
// Loads one triangle into the intersection detector, sweeps its clamped
// bounding box row-major and streams out every point reported inside.
module rasterizer_scan_controller
   import rasterizer_pkg::*;
#(
   parameter int VERT_RESOLUTION  = DEF_VERT_RESOLUTION,
   parameter int HORIZ_RESOLUTION = DEF_HORIZ_RESOLUTION,
   parameter int DETECT_LATENCY   = 4,
   localparam int XW = calc_xw(HORIZ_RESOLUTION),
   localparam int YW = calc_yw(VERT_RESOLUTION)
) (
   input  logic          i_clk,
   input  logic          i_arst,
   input  logic          i_start,
   input  logic [XW-1:0] i_triangle_point_0_x,
   input  logic [YW-1:0] i_triangle_point_0_y,
   input  logic [XW-1:0] i_triangle_point_1_x,
   input  logic [YW-1:0] i_triangle_point_1_y,
   input  logic [XW-1:0] i_triangle_point_2_x,
   input  logic [YW-1:0] i_triangle_point_2_y,
   output logic          o_busy,
   output logic          o_load_triangle,
   output logic [XW-1:0] o_triangle_point_0_x,
   output logic [YW-1:0] o_triangle_point_0_y,
   output logic [XW-1:0] o_triangle_point_1_x,
   output logic [YW-1:0] o_triangle_point_1_y,
   output logic [XW-1:0] o_triangle_point_2_x,
   output logic [YW-1:0] o_triangle_point_2_y,
   input  logic          i_triangle_loaded,
   output logic [2*XW-1:0] o_current_point_x,
   output logic [2*YW-1:0] o_current_point_y,
   input  logic          i_point_inside_triangle,
   output logic          o_pixel_valid,
   output logic [XW-1:0] o_pixel_x,
   output logic [YW-1:0] o_pixel_y,
   input  logic          i_pixel_ready,
   output logic          o_done
);

   localparam int CW = (DETECT_LATENCY > 1) ? $clog2(DETECT_LATENCY) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DETECT_LATENCY - 1);

   scan_state_e   state_q;
   logic          busy_q, load_q, done_q, pixel_valid_q;
   logic [XW-1:0] p0x_q, p1x_q, p2x_q;
   logic [YW-1:0] p0y_q, p1y_q, p2y_q;
   logic [XW-1:0] xmin_q, xmax_q, cur_x_q, cur_x_d, pixel_x_q;
   logic [YW-1:0] ymin_q, ymax_q, cur_y_q, cur_y_d, pixel_y_q;
   logic [CW-1:0] cnt_q;
   logic [XW-1:0] box_xmin_d, box_xmax_d;
   logic [YW-1:0] box_ymin_d, box_ymax_d;
   logic          last_point, point_done;

   rasterizer_bounding_box #(
      .VERT_RESOLUTION (VERT_RESOLUTION),
      .HORIZ_RESOLUTION(HORIZ_RESOLUTION)
   ) u_bounding_box (
      .point_0_x_i(i_triangle_point_0_x),
      .point_0_y_i(i_triangle_point_0_y),
      .point_1_x_i(i_triangle_point_1_x),
      .point_1_y_i(i_triangle_point_1_y),
      .point_2_x_i(i_triangle_point_2_x),
      .point_2_y_i(i_triangle_point_2_y),
      .xmin_o     (box_xmin_d),
      .xmax_o     (box_xmax_d),
      .ymin_o     (box_ymin_d),
      .ymax_o     (box_ymax_d)
   );

   always_comb begin
      last_point = (cur_x_q == xmax_q) && (cur_y_q == ymax_q);
      if (cur_x_q == xmax_q) begin
         cur_x_d = xmin_q;
         cur_y_d = cur_y_q + 1'b1;
      end else begin
         cur_x_d = cur_x_q + 1'b1;
         cur_y_d = cur_y_q;
      end
   end

   // A point retires either on an outside sample or on a completed handshake.
   assign point_done = ((state_q == ST_SETTLE) && (cnt_q == LAST_CNT) && !i_point_inside_triangle)
                    || ((state_q == ST_EMIT) && i_pixel_ready);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q       <= ST_IDLE;
         busy_q        <= 1'b0;
         load_q        <= 1'b0;
         done_q        <= 1'b0;
         pixel_valid_q <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         p0x_q         <= '0;
         p0y_q         <= '0;
         p1x_q         <= '0;
         p1y_q         <= '0;
         p2x_q         <= '0;
         p2y_q         <= '0;
         xmin_q        <= '0;
         xmax_q        <= '0;
         ymin_q        <= '0;
         ymax_q        <= '0;
         cur_x_q       <= '0;
         cur_y_q       <= '0;
         cnt_q         <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  p0x_q   <= i_triangle_point_0_x;
                  p0y_q   <= i_triangle_point_0_y;
                  p1x_q   <= i_triangle_point_1_x;
                  p1y_q   <= i_triangle_point_1_y;
                  p2x_q   <= i_triangle_point_2_x;
                  p2y_q   <= i_triangle_point_2_y;
                  xmin_q  <= box_xmin_d;
                  xmax_q  <= box_xmax_d;
                  ymin_q  <= box_ymin_d;
                  ymax_q  <= box_ymax_d;
                  busy_q  <= 1'b1;
                  load_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               load_q  <= 1'b0;
               state_q <= ST_WAIT_LOADED;
            end
            ST_WAIT_LOADED: begin
               if (i_triangle_loaded) begin
                  cur_x_q <= xmin_q;
                  cur_y_q <= ymin_q;
                  cnt_q   <= '0;
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE, ST_EMIT: begin
               if (point_done) begin
                  pixel_valid_q <= 1'b0;
                  if (last_point) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_DONE;
                  end else begin
                     cur_x_q <= cur_x_d;
                     cur_y_q <= cur_y_d;
                     cnt_q   <= '0;
                     state_q <= ST_SETTLE;
                  end
               end else if (state_q == ST_SETTLE) begin
                  if (cnt_q == LAST_CNT) begin
                     pixel_valid_q <= 1'b1;
                     pixel_x_q     <= cur_x_q;
                     pixel_y_q     <= cur_y_q;
                     state_q       <= ST_EMIT;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_busy               = busy_q;
   assign o_load_triangle      = load_q;
   assign o_done               = done_q;
   assign o_triangle_point_0_x = p0x_q;
   assign o_triangle_point_0_y = p0y_q;
   assign o_triangle_point_1_x = p1x_q;
   assign o_triangle_point_1_y = p1y_q;
   assign o_triangle_point_2_x = p2x_q;
   assign o_triangle_point_2_y = p2y_q;
   assign o_current_point_x    = {{XW{1'b0}}, cur_x_q};
   assign o_current_point_y    = {{YW{1'b0}}, cur_y_q};
   assign o_pixel_valid        = pixel_valid_q;
   assign o_pixel_x            = pixel_x_q;
   assign o_pixel_y            = pixel_y_q;

endmodule

// File: tb/tb_rasterizer_scan_controller.sv
// Bench for the scan controller: behavioural detector and sink models plus
// an arithmetic reference of the expected row-major inside-pixel list.
module tb_rasterizer_scan_controller;

   localparam int V     = 60;
   localparam int H     = 80;
   localparam int DL    = 4;
   localparam int XW    = 7;
   localparam int YW    = 6;
   localparam int STALL = 10;

   logic i_clk = 1'b0;
   logic i_arst, i_start, i_triangle_loaded, i_point_inside_triangle, i_pixel_ready;
   logic [XW-1:0] i_triangle_point_0_x, i_triangle_point_1_x, i_triangle_point_2_x;
   logic [YW-1:0] i_triangle_point_0_y, i_triangle_point_1_y, i_triangle_point_2_y;
   logic o_busy, o_load_triangle, o_pixel_valid, o_done;
   logic [XW-1:0] o_triangle_point_0_x, o_triangle_point_1_x, o_triangle_point_2_x, o_pixel_x;
   logic [YW-1:0] o_triangle_point_0_y, o_triangle_point_1_y, o_triangle_point_2_y, o_pixel_y;
   logic [2*XW-1:0] o_current_point_x;
   logic [2*YW-1:0] o_current_point_y;

   rasterizer_scan_controller #(
      .VERT_RESOLUTION (V),
      .HORIZ_RESOLUTION(H),
      .DETECT_LATENCY  (DL)
   ) dut (
      .i_clk                  (i_clk),
      .i_arst                 (i_arst),
      .i_start                (i_start),
      .i_triangle_point_0_x   (i_triangle_point_0_x),
      .i_triangle_point_0_y   (i_triangle_point_0_y),
      .i_triangle_point_1_x   (i_triangle_point_1_x),
      .i_triangle_point_1_y   (i_triangle_point_1_y),
      .i_triangle_point_2_x   (i_triangle_point_2_x),
      .i_triangle_point_2_y   (i_triangle_point_2_y),
      .o_busy                 (o_busy),
      .o_load_triangle        (o_load_triangle),
      .o_triangle_point_0_x   (o_triangle_point_0_x),
      .o_triangle_point_0_y   (o_triangle_point_0_y),
      .o_triangle_point_1_x   (o_triangle_point_1_x),
      .o_triangle_point_1_y   (o_triangle_point_1_y),
      .o_triangle_point_2_x   (o_triangle_point_2_x),
      .o_triangle_point_2_y   (o_triangle_point_2_y),
      .i_triangle_loaded      (i_triangle_loaded),
      .o_current_point_x      (o_current_point_x),
      .o_current_point_y      (o_current_point_y),
      .i_point_inside_triangle(i_point_inside_triangle),
      .o_pixel_valid          (o_pixel_valid),
      .o_pixel_x              (o_pixel_x),
      .o_pixel_y              (o_pixel_y),
      .i_pixel_ready          (i_pixel_ready),
      .o_done                 (o_done)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Inclusive edge-function test, orientation independent.
   function automatic bit inside_tri(input int ax, ay, bx, by, cx, cy, px, py);
      int e0, e1, e2;
      e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
      e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
      e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
      return ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) || ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
   endfunction

   function automatic logic any_out();
      return |{o_busy, o_load_triangle, o_triangle_point_0_x, o_triangle_point_0_y,
               o_triangle_point_1_x, o_triangle_point_1_y, o_triangle_point_2_x,
               o_triangle_point_2_y, o_current_point_x, o_current_point_y,
               o_pixel_valid, o_pixel_x, o_pixel_y, o_done};
   endfunction

   // ---------------- reference model ----------------
   int exp_q[$];
   int bx_min, bx_max, by_min, by_max;

   task automatic build_expected(input int x0, y0, x1, y1, x2, y2);
      int lo, hi;
      lo = (x0 < x1) ? x0 : x1;  lo = (x2 < lo) ? x2 : lo;
      hi = (x0 > x1) ? x0 : x1;  hi = (x2 > hi) ? x2 : hi;
      bx_min = (lo > H - 1) ? H - 1 : lo;
      bx_max = (hi > H - 1) ? H - 1 : hi;
      lo = (y0 < y1) ? y0 : y1;  lo = (y2 < lo) ? y2 : lo;
      hi = (y0 > y1) ? y0 : y1;  hi = (y2 > hi) ? y2 : hi;
      by_min = (lo > V - 1) ? V - 1 : lo;
      by_max = (hi > V - 1) ? V - 1 : hi;
      exp_q.delete();
      for (int y = by_min; y <= by_max; y++)
         for (int x = bx_min; x <= bx_max; x++)
            if (inside_tri(x0, y0, x1, y1, x2, y2, x, y)) exp_q.push_back(y * 256 + x);
   endtask

   // ---------------- detector and sink models ----------------
   int det_v[6];
   int ack_wait   = 0;
   int age        = 0;
   int ready_mode = 0;
   int stall_left = 0;
   logic [2*XW-1:0] last_cx, hold_cx;
   logic [2*YW-1:0] last_cy, hold_cy;
   logic [XW-1:0]   hold_px;
   logic [YW-1:0]   hold_py;

   initial begin
      i_triangle_loaded       = 1'b0;
      i_point_inside_triangle = 1'b0;
      i_pixel_ready           = 1'b1;
      last_cx = '0;
      last_cy = '0;
      forever begin
         @(posedge i_clk);
         #1;
         i_triangle_loaded = 1'b0;
         if (i_arst) begin
            ack_wait = 0;
         end else if (o_load_triangle) begin
            det_v[0] = int'(o_triangle_point_0_x); det_v[1] = int'(o_triangle_point_0_y);
            det_v[2] = int'(o_triangle_point_1_x); det_v[3] = int'(o_triangle_point_1_y);
            det_v[4] = int'(o_triangle_point_2_x); det_v[5] = int'(o_triangle_point_2_y);
            ack_wait = 2;
         end else if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) i_triangle_loaded = 1'b1;
         end
         if (o_load_triangle || o_current_point_x != last_cx || o_current_point_y != last_cy)
            age = 0;
         else if (age < 1000)
            age++;
         last_cx = o_current_point_x;
         last_cy = o_current_point_y;
         // Until the result has settled the detector output is garbage.
         if (age >= DL - 1)
            i_point_inside_triangle = inside_tri(det_v[0], det_v[1], det_v[2], det_v[3],
                                                 det_v[4], det_v[5], int'(o_current_point_x),
                                                 int'(o_current_point_y));
         else
            i_point_inside_triangle = 1'($urandom);
         case (ready_mode)
            1: i_pixel_ready = ($urandom_range(0, 2) != 0);
            2: begin
               if (stall_left > 0 && (o_pixel_valid || stall_left < STALL)) begin
                  if (stall_left == STALL) begin
                     hold_px = o_pixel_x;  hold_py = o_pixel_y;
                     hold_cx = o_current_point_x;  hold_cy = o_current_point_y;
                  end else begin
                     check_value("bp_pixel_stable", {o_pixel_valid, o_pixel_x, o_pixel_y},
                                 {1'b1, hold_px, hold_py});
                     check_value("bp_point_stable", {o_current_point_x, o_current_point_y},
                                 {hold_cx, hold_cy});
                  end
                  i_pixel_ready = 1'b0;
                  stall_left--;
               end else begin
                  i_pixel_ready = 1'b1;
               end
            end
            default: i_pixel_ready = 1'b1;
         endcase
      end
   end

   // ---------------- output monitor ----------------
   int   got_q[$];
   int   done_cnt = 0, done_cyc = 0, hs_cyc = 0, ack_cyc = 0;
   logic busy_at_done = 1'b0;

   always @(negedge i_clk) begin
      if (o_pixel_valid && i_pixel_ready) begin
         got_q.push_back(int'(o_pixel_y) * 256 + int'(o_pixel_x));
         hs_cyc = cyc;
      end
      if (o_done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = o_busy;
      end
      if (i_triangle_loaded) ack_cyc = cyc;
   end

   task automatic drive_vertices(input int x0, y0, x1, y1, x2, y2);
      i_triangle_point_0_x = XW'(x0);  i_triangle_point_0_y = YW'(y0);
      i_triangle_point_1_x = XW'(x1);  i_triangle_point_1_y = YW'(y1);
      i_triangle_point_2_x = XW'(x2);  i_triangle_point_2_y = YW'(y2);
   endtask

   task automatic run_scan(input string tag, input int x0, y0, x1, y1, x2, y2,
                           input int mode, input bit inject);
      int mism, oob, w, h, scan_cycles;
      bit injected;
      injected = 1'b0;
      build_expected(x0, y0, x1, y1, x2, y2);
      w = bx_max - bx_min + 1;
      h = by_max - by_min + 1;
      ready_mode = mode;
      stall_left = (mode == 2) ? STALL : 0;
      got_q.delete();
      done_cnt = 0;
      @(negedge i_clk);
      drive_vertices(x0, y0, x1, y1, x2, y2);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check_value({tag, "_load_busy"}, {30'd0, o_load_triangle, o_busy}, 32'd3);
      @(negedge i_clk);
      check_value({tag, "_load_once"}, {31'd0, o_load_triangle}, 32'd0);
      for (int i = 0; i < 40000 && done_cnt == 0; i++) begin
         if (inject && !injected && got_q.size() > 0) begin
            drive_vertices(3, 3, 40, 40, 7, 50);
            i_start  = 1'b1;
            injected = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         @(negedge i_clk);
      end
      i_start = 1'b0;
      check_value({tag, "_done_seen"}, done_cnt, 1);
      repeat (3) @(negedge i_clk);
      check_value({tag, "_done_once"}, done_cnt, 1);
      check_value({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
      check_value({tag, "_busy_after"}, {31'd0, o_busy}, 32'd0);
      check_value({tag, "_npix"}, got_q.size(), exp_q.size());
      mism = 0;
      oob  = 0;
      foreach (got_q[i]) begin
         if (i >= exp_q.size() || got_q[i] != exp_q[i]) mism++;
         if ((got_q[i] % 256) < bx_min || (got_q[i] % 256) > bx_max ||
             (got_q[i] / 256) < by_min || (got_q[i] / 256) > by_max) oob++;
      end
      check_value({tag, "_pixel_order"}, mism, 0);
      check_value({tag, "_in_box"}, oob, 0);
      check_value({tag, "_last_x"}, o_current_point_x, bx_max);
      check_value({tag, "_last_y"}, o_current_point_y, by_max);
      check_value({tag, "_tri_x"}, {o_triangle_point_0_x, o_triangle_point_1_x, o_triangle_point_2_x},
                  {XW'(x0), XW'(x1), XW'(x2)});
      check_value({tag, "_tri_y"}, {o_triangle_point_0_y, o_triangle_point_1_y, o_triangle_point_2_y},
                  {YW'(y0), YW'(y1), YW'(y2)});
      scan_cycles = done_cyc - ack_cyc - 1;
      if (mode == 0)
         check_value({tag, "_cycles"}, scan_cycles, w * h * DL + exp_q.size());
      if (exp_q.size() > 0 && exp_q[exp_q.size() - 1] == by_max * 256 + bx_max)
         check_value({tag, "_done_after_hs"}, done_cyc, hs_cyc + 1);
      $display("scan %s box=%0dx%0d pixels=%0d expected=%0d cycles=%0d",
               tag, w, h, got_q.size(), exp_q.size(), scan_cycles);
   endtask

   task automatic midscan_reset();
      ready_mode = 0;
      stall_left = 0;
      @(negedge i_clk);
      drive_vertices(0, 0, 30, 0, 0, 30);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (4) @(negedge i_clk);
      check_value("midrst_busy_before", {31'd0, o_busy}, 32'd1);
      #2;
      i_arst = 1'b1;
      #1;
      check_value("midrst_outputs_zero", {31'd0, any_out()}, 32'd0);
      @(negedge i_clk);
      i_arst = 1'b0;
      got_q.delete();
      done_cnt = 0;
      repeat (50) @(negedge i_clk);
      check_value("midrst_no_pixels", got_q.size(), 0);
      check_value("midrst_no_done", done_cnt, 0);
      check_value("midrst_idle", {30'd0, o_busy, o_load_triangle}, 32'd0);
      $display("scan midscan_reset pixels_after=%0d done_after=%0d", got_q.size(), done_cnt);
   endtask

   initial begin
      i_arst  = 1'b1;
      i_start = 1'b0;
      drive_vertices(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge i_clk);
      check_value("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
      i_arst = 1'b0;

      run_scan("nominal", 10, 10, 10, 50, 50, 25, 0, 1'b0);
      run_scan("degenerate", 5, 5, 5, 5, 5, 5, 0, 1'b0);
      run_scan("backpressure", 20, 5, 34, 12, 24, 22, 2, 1'b0);
      check_value("bp_stall_consumed", stall_left, 0);
      run_scan("clamp_ignore", 100, 3, 60, 8, 70, 12, 1, 1'b1);
      midscan_reset();
      run_scan("restart", 12, 4, 30, 9, 16, 18, 0, 1'b0);
      for (int t = 0; t < 3; t++) begin
         int xb, yb;
         xb = $urandom_range(0, 107);
         yb = $urandom_range(0, 43);
         run_scan($sformatf("rand%0d", t),
                  xb + $urandom_range(0, 20), yb + $urandom_range(0, 20),
                  xb + $urandom_range(0, 20), yb + $urandom_range(0, 20),
                  xb + $urandom_range(0, 20), yb + $urandom_range(0, 20),
                  1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
